spi_frame_listener: RTL and testbench

- Parametrised successor to the fixed 3-byte SPI command listener.
- Consumes the byte stream from the SPI slave (byte plus valid strobe).
- Hunts for a header byte matching a masked pattern and assembles a frame of FRAME_BYTES bytes. The header carries a channel index; each completed frame is written to a per-channel holding register with a sticky interrupt, an acknowledge input and overrun detection.
- An inter-byte timeout aborts partial frames so the stream resynchronises after dropped bytes.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_frame_listener_if.sv | 34 +++
 rtl/spi_byte_timeout.sv | 39 +++
 rtl/spi_frame_listener.sv | 150 +++++++++++++++
 tb/tb_spi_frame_listener.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI command-decoder definitions
// Purpose: state encoding, header map defaults and a constant clog2 helper
// shared by every SPI-side listener. No ports.
package spi_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } spi_state_e;

  // One header map for all SPI command decoders.
  localparam logic [7:0] SPI_HDR_MASK  = 8'hE0;
  localparam logic [7:0] SPI_HDR_VALUE = 8'h20;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_frame_listener_if.sv
// rtl/spi_frame_listener_if.sv - byte-stream in / frame registers out bundle
// Purpose: groups the listener's stream, acknowledge and result signals.
// Ports (signals):
//   spi_slave_data_valid, spi_slave_byte : byte strobe and data from the SPI slave
//   irq_ack                              : per-channel irq/overrun clear
//   ch_data, frame_valid, frame_ch       : committed frames and commit pulse
//   irq, overrun, frame_err              : per-channel flags and timeout pulse
// Modports: master drives the stream/acks, slave is the listener.
interface spi_frame_listener_if import spi_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int FRAME_BYTES = 3
);
  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  logic                            spi_slave_data_valid;
  logic [7:0]                      spi_slave_byte;
  logic [NUM_CH-1:0]               irq_ack;
  logic [NUM_CH*8*FRAME_BYTES-1:0] ch_data;
  logic                            frame_valid;
  logic [CH_W-1:0]                 frame_ch;
  logic [NUM_CH-1:0]               irq;
  logic [NUM_CH-1:0]               overrun;
  logic                            frame_err;

  modport master (
    output spi_slave_data_valid, spi_slave_byte, irq_ack,
    input  ch_data, frame_valid, frame_ch, irq, overrun, frame_err
  );

  modport slave (
    input  spi_slave_data_valid, spi_slave_byte, irq_ack,
    output ch_data, frame_valid, frame_ch, irq, overrun, frame_err
  );
endinterface

// File: rtl/spi_byte_timeout.sv
// rtl/spi_byte_timeout.sv - saturating inter-byte idle counter
// Purpose: counts enabled idle cycles; expire_o pulses in the cycle the
// count would reach LIMIT. LIMIT == 0 disables expiry.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clear (wins over enable, also suppresses expiry)
//   en_i      : count this cycle
//   expire_o  : one-cycle expiry indication (combinational)
module spi_byte_timeout import spi_pkg::*; #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = (clog2(LIMIT + 1) > 0) ? clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (LIMIT != 0) && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expire on the idle cycle that brings the count to LIMIT, so a byte
  // arriving in that same cycle (clr_i) still beats the timeout.
  assign expire_o = (LIMIT != 0) && en_i && !clr_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_frame_listener.sv
// rtl/spi_frame_listener.sv - header-synchronised multi-channel SPI frame listener
// Purpose: hunts for a masked header byte, assembles FRAME_BYTES-byte frames,
// commits each to a per-channel register with sticky irq/overrun flags, and
// drops partial frames after an inter-byte timeout.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spi_frame_listener_if.slave (stream in, acks in, frames/flags out)
module spi_frame_listener import spi_pkg::*; #(
  parameter int         FRAME_BYTES    = 3,
  parameter logic [7:0] HDR_MASK       = SPI_HDR_MASK,
  parameter logic [7:0] HDR_VALUE      = SPI_HDR_VALUE,
  parameter int         NUM_CH         = 4,
  parameter int         CH_LSB         = 0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_frame_listener_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int FW    = 8 * FRAME_BYTES;
  localparam int CNT_W = clog2(FRAME_BYTES);

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FW-1:0]       asm_q, asm_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH*FW-1:0] ch_data_q, ch_data_d;
  logic [CH_W-1:0]     frame_ch_q, frame_ch_d;
  logic                frame_valid_q, frame_err_q;
  logic [NUM_CH-1:0]   irq_q, irq_d, ovr_q, ovr_d;

  logic                valid;
  logic [7:0]          rx_byte;
  logic [CH_W-1:0]     hdr_ch;
  logic                is_hdr;
  logic                complete;
  logic                expire;
  logic [FW-1:0]       frame_word;

  assign valid   = bus.spi_slave_data_valid;
  assign rx_byte = bus.spi_slave_byte;
  assign hdr_ch  = rx_byte[CH_LSB +: CH_W];
  assign is_hdr  = ((rx_byte & HDR_MASK) == HDR_VALUE) && (int'(hdr_ch) < NUM_CH);

  spi_byte_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q == HUNT) || valid),
    .en_i     (state_q == COLLECT),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    asm_d      = asm_q;
    ch_d       = ch_q;
    complete   = 1'b0;
    // Assembly buffer with the incoming byte placed at position count_q
    // (position 0 = header in the MSBs).
    frame_word = asm_q;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (CNT_W'(k) == count_q) frame_word[(FRAME_BYTES-1-k)*8 +: 8] = rx_byte;
    end

    case (state_q)
      HUNT: begin
        if (valid && is_hdr) begin
          asm_d   = {rx_byte, {(FW-8){1'b0}}};
          ch_d    = hdr_ch;
          count_d = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Bytes are stored unconditionally: no resync on header-like data.
        if (valid) begin
          asm_d   = frame_word;
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(FRAME_BYTES - 1)) begin
            complete = 1'b1;
            count_d  = '0;
            state_d  = HUNT;
          end
        end else if (expire) begin
          count_d = '0;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    ch_data_d  = ch_data_q;
    frame_ch_d = frame_ch_q;
    if (complete) begin
      frame_ch_d = ch_q;
      for (int c = 0; c < NUM_CH; c++) begin
        if (CH_W'(c) == ch_q) ch_data_d[c*FW +: FW] = frame_word;
      end
    end
  end

  // Commit sets irq; a same-cycle ack retires the old frame so overrun
  // only records an unacknowledged previous frame.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic commit_c;
    logic ack_c;
    assign commit_c = complete && (ch_q == CH_W'(c));
    assign ack_c    = bus.irq_ack[c];
    assign irq_d[c] = commit_c | (irq_q[c] & ~ack_c);
    assign ovr_d[c] = commit_c ? (~ack_c & (irq_q[c] | ovr_q[c]))
                               : (ovr_q[c] & ~ack_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      count_q       <= '0;
      asm_q         <= '0;
      ch_q          <= '0;
      ch_data_q     <= '0;
      frame_ch_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      irq_q         <= '0;
      ovr_q         <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      asm_q         <= asm_d;
      ch_q          <= ch_d;
      ch_data_q     <= ch_data_d;
      frame_ch_q    <= frame_ch_d;
      frame_valid_q <= complete;
      frame_err_q   <= expire;
      irq_q         <= irq_d;
      ovr_q         <= ovr_d;
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ch    = frame_ch_q;
  assign bus.irq         = irq_q;
  assign bus.overrun     = ovr_q;
  assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_frame_listener.sv
// tb/tb_spi_frame_listener.sv - self-checking bench for spi_frame_listener
module tb_spi_frame_listener;
  localparam int FB  = 3;
  localparam int NCH = 4;
  localparam int TO  = 16;
  localparam int FW  = 8 * FB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_listener_if #(.NUM_CH(NCH), .FRAME_BYTES(FB)) bus ();

  spi_frame_listener #(
    .FRAME_BYTES(FB), .HDR_MASK(8'hE0), .HDR_VALUE(8'h20),
    .NUM_CH(NCH), .CH_LSB(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame as a byte queue, timeout as an idle count.
  logic [7:0]     mq[$];
  int             m_idle;
  logic [FW-1:0]  m_data [NCH];
  logic [NCH-1:0] m_irq, m_ovr;
  logic           m_fv, m_ferr;
  logic [1:0]     m_fch;

  function automatic bit is_header(input logic [7:0] b);
    return (b & 8'hE0) == 8'h20;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_idle = 0;
    for (int c = 0; c < NCH; c++) m_data[c] = '0;
    m_irq = '0; m_ovr = '0; m_fv = 1'b0; m_ferr = 1'b0; m_fch = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic [NCH-1:0] ack);
    logic [NCH-1:0] irq_n, ovr_n;
    logic [7:0] h;
    int ch;
    irq_n = m_irq & ~ack;
    ovr_n = m_ovr & ~ack;
    m_fv = 1'b0;
    m_ferr = 1'b0;
    if (mq.size() == 0) begin
      if (v && is_header(b)) begin
        mq.push_back(b);
        m_idle = 0;
      end
    end else if (v) begin
      mq.push_back(b);
      m_idle = 0;
      if (mq.size() == FB) begin
        h = mq[0];
        ch = int'(h[1:0]);
        m_data[ch] = {mq[0], mq[1], mq[2]};
        irq_n[ch] = 1'b1;
        ovr_n[ch] = !ack[ch] && (m_irq[ch] || m_ovr[ch]);
        m_fv = 1'b1;
        m_fch = 2'(ch);
        mq.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_ferr = 1'b1;
        mq.delete();
        m_idle = 0;
      end
    end
    m_irq = irq_n;
    m_ovr = ovr_n;
  endtask

  function automatic logic [NCH*FW-1:0] m_flat();
    logic [NCH*FW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*FW +: FW] = m_data[c];
    return r;
  endfunction

  task automatic check_model();
    check("model_ch_data", bus.ch_data, m_flat());
    check("model_irq", bus.irq, m_irq);
    check("model_overrun", bus.overrun, m_ovr);
    check("model_frame_valid", bus.frame_valid, m_fv);
    check("model_frame_ch", bus.frame_ch, m_fch);
    check("model_frame_err", bus.frame_err, m_ferr);
  endtask

  task automatic tick(input logic v, input logic [7:0] b, input logic [NCH-1:0] ack);
    bus.spi_slave_data_valid = v;
    bus.spi_slave_byte = b;
    bus.irq_ack = ack;
    @(posedge clk);
    model_step(v, b, ack);
    #1;
    check_model();
    if (bus.frame_valid) fv_seen++;
    if (bus.frame_err) err_seen++;
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, '0);
  endtask

  task automatic do_reset();
    bus.spi_slave_data_valid = 1'b0;
    bus.spi_slave_byte = 8'h00;
    bus.irq_ack = '0;
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_ch_data", bus.ch_data, '0);
    check("rst_irq", bus.irq, '0);
    check("rst_overrun", bus.overrun, '0);
    check("rst_frame_valid", bus.frame_valid, '0);
    check("rst_frame_ch", bus.frame_ch, '0);
    check("rst_frame_err", bus.frame_err, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          nb;
    logic [47:0] bytes;      // left-justified, first byte in the MSBs
    int          gap;        // idle cycles before every byte after the first
    logic [3:0]  ack_last;   // irq_ack driven with the last byte
    int          exp_fv;
    int          exp_err;
    int          exp_ch;
    logic [23:0] exp_data;
    logic [3:0]  exp_irq;
    logic [3:0]  exp_ovr;
    logic [3:0]  ack_after;
  } vec_t;

  vec_t vec[10];

  initial begin
    vec[0] = '{nb:3, bytes:48'h21ABCD000000, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:1, exp_data:24'h21ABCD, exp_irq:4'b0010, exp_ovr:4'b0000, ack_after:4'b0010};
    vec[1] = '{nb:5, bytes:48'h55FF20010200, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:0, exp_data:24'h200102, exp_irq:4'b0001, exp_ovr:4'b0000, ack_after:4'b0001};
    vec[2] = '{nb:3, bytes:48'h221111000000, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:2, exp_data:24'h221111, exp_irq:4'b0100, exp_ovr:4'b0000, ack_after:4'b0000};
    vec[3] = '{nb:3, bytes:48'h223344000000, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:2, exp_data:24'h223344, exp_irq:4'b0100, exp_ovr:4'b0100, ack_after:4'b0100};
    vec[4] = '{nb:2, bytes:48'h209900000000, gap:16, ack_last:4'h0, exp_fv:0, exp_err:1, exp_ch:0, exp_data:24'h200102, exp_irq:4'b0000, exp_ovr:4'b0000, ack_after:4'b0000};
    vec[5] = '{nb:3, bytes:48'h221133000000, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:2, exp_data:24'h221133, exp_irq:4'b0100, exp_ovr:4'b0000, ack_after:4'b0100};
    vec[6] = '{nb:3, bytes:48'h235AA5000000, gap:15, ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:3, exp_data:24'h235AA5, exp_irq:4'b1000, exp_ovr:4'b0000, ack_after:4'b0000};
    vec[7] = '{nb:3, bytes:48'h230102000000, gap:0,  ack_last:4'h8, exp_fv:1, exp_err:0, exp_ch:3, exp_data:24'h230102, exp_irq:4'b1000, exp_ovr:4'b0000, ack_after:4'b1000};
    vec[8] = '{nb:3, bytes:48'h202122000000, gap:0,  ack_last:4'h0, exp_fv:1, exp_err:0, exp_ch:0, exp_data:24'h202122, exp_irq:4'b0001, exp_ovr:4'b0000, ack_after:4'b0001};
    vec[9] = '{nb:6, bytes:48'h210102220304, gap:0,  ack_last:4'h0, exp_fv:2, exp_err:0, exp_ch:2, exp_data:24'h220304, exp_irq:4'b0110, exp_ovr:4'b0000, ack_after:4'b0110};

    bus.spi_slave_data_valid = 1'b0;
    bus.spi_slave_byte = 8'h00;
    bus.irq_ack = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Table-driven frames.
    for (int i = 0; i < 10; i++) begin
      fv_seen = 0;
      err_seen = 0;
      for (int k = 0; k < vec[i].nb; k++) begin
        if (k > 0) repeat (vec[i].gap) idle();
        tick(1'b1, vec[i].bytes[47-8*k -: 8], (k == vec[i].nb - 1) ? vec[i].ack_last : 4'h0);
      end
      check($sformatf("v%0d_fv_after_last", i), bus.frame_valid, (vec[i].exp_fv != 0));
      if (vec[i].exp_fv != 0) check($sformatf("v%0d_frame_ch", i), bus.frame_ch, vec[i].exp_ch);
      idle();
      check($sformatf("v%0d_fv_pulses", i), fv_seen, vec[i].exp_fv);
      check($sformatf("v%0d_err_pulses", i), err_seen, vec[i].exp_err);
      check($sformatf("v%0d_slice", i), bus.ch_data[vec[i].exp_ch*FW +: FW], vec[i].exp_data);
      check($sformatf("v%0d_irq", i), bus.irq, vec[i].exp_irq);
      check($sformatf("v%0d_overrun", i), bus.overrun, vec[i].exp_ovr);
      if (vec[i].ack_after != 4'h0) begin
        tick(1'b0, 8'h00, vec[i].ack_after);
        check($sformatf("v%0d_irq_acked", i), bus.irq, vec[i].exp_irq & ~vec[i].ack_after);
        check($sformatf("v%0d_ovr_acked", i), bus.overrun, 4'b0000);
      end
    end

    // Reset in the middle of a frame, then a clean frame.
    tick(1'b1, 8'h21, '0);
    tick(1'b1, 8'hAB, '0);
    do_reset();
    tick(1'b1, 8'h21, '0);
    tick(1'b1, 8'hCC, '0);
    tick(1'b1, 8'hDD, '0);
    check("rstmid_frame_valid", bus.frame_valid, 1'b1);
    check("rstmid_slice1", bus.ch_data[1*FW +: FW], 24'h21CCDD);
    check("rstmid_other_slices", {bus.ch_data[3*FW +: FW], bus.ch_data[2*FW +: FW], bus.ch_data[0 +: FW]}, 72'h0);
    check("rstmid_irq", bus.irq, 4'b0010);
    idle();

    // Randomised traffic against the model.
    begin
      int burst;
      int r;
      logic v;
      logic [7:0] b;
      logic [3:0] ack;
      burst = 0;
      for (int i = 0; i < 2000; i++) begin
        if (burst > 0) begin
          v = 1'b0;
          burst--;
        end else begin
          r = $urandom_range(0, 99);
          if (r < 3) burst = $urandom_range(10, 20);
          v = (r < 60);
        end
        if ($urandom_range(0, 1) == 1) b = {3'b001, 3'b000, 2'($urandom_range(0, 3))};
        else b = 8'($urandom_range(0, 255));
        ack = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        tick(v, b, ack);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
